// File: rtl/instr_fifo.sv
// Decode-to-dispatch queue: 2^DEPTH_LOG2 entries, 1-cycle fall-through, push ignored while full, flush wins.
// Defining INSTR_FIFO_BYPASS_EN lets a push into an empty queue reach the head combinationally.
module instr_fifo #(
  parameter int DECODE_INFO_DW = 209,
  parameter int DEPTH_LOG2     = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      flush,
  input  logic                      instrFifo_push,
  input  logic [DECODE_INFO_DW-1:0] decode_microInstr,
  output logic                      instrFifo_full,
  input  logic                      instrFifo_pop,
  output logic                      instrFifo_empty,
  output logic [DECODE_INFO_DW-1:0] instrFifo_microInstr,
  output logic [DEPTH_LOG2:0]       instrFifo_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]             count_w;
  logic                      full_w, empty_w;
  logic                      push_acc, pop_acc;
  logic                      bypass_vld, bypass_take;
  logic [DECODE_INFO_DW-1:0] mem_q [DEPTH];

  assign count_w = wr_ptr_q - rd_ptr_q;
  assign full_w  = (count_w == PW'(DEPTH));
  assign empty_w = (count_w == '0);

`ifdef INSTR_FIFO_BYPASS_EN
  assign bypass_vld  = empty_w & instrFifo_push & ~flush;
  assign bypass_take = bypass_vld & instrFifo_pop;
`else
  assign bypass_vld  = 1'b0;
  assign bypass_take = 1'b0;
`endif

  always_comb begin
    push_acc = instrFifo_push & ~full_w & ~flush & ~bypass_take;
    pop_acc  = instrFifo_pop & ~empty_w & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_acc)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately left out of reset; only the pointers define validity.
  always_ff @(posedge CLK) begin
    if (push_acc) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= decode_microInstr;
  end

  always_comb begin
    instrFifo_microInstr = '0;
    if (bypass_vld)
      instrFifo_microInstr = decode_microInstr;
    else if (!empty_w)
      instrFifo_microInstr = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  end

  assign instrFifo_full  = full_w;
  assign instrFifo_empty = empty_w & ~bypass_vld;
  assign instrFifo_count = count_w;

endmodule

// File: tb/tb_instr_fifo.sv
// Directed bench for instr_fifo: fill, concurrent, wrap, flush, async reset, bypass behaviour.
module tb_instr_fifo;
  localparam int DW = 209;

  logic          CLK = 1'b0;
  logic          RST;
  logic          flush;
  logic          push;
  logic [DW-1:0] din;
  logic          full;
  logic          pop;
  logic          empty;
  logic [DW-1:0] head;
  logic [2:0]    count;

  int total = 0;
  int bad   = 0;

  instr_fifo dut (
    .CLK                  (CLK),
    .RST                  (RST),
    .flush                (flush),
    .instrFifo_push       (push),
    .decode_microInstr    (din),
    .instrFifo_full       (full),
    .instrFifo_pop        (pop),
    .instrFifo_empty      (empty),
    .instrFifo_microInstr (head),
    .instrFifo_count      (count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and checks happen 2 time units after it.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic drive(input logic p, input logic [DW-1:0] d, input logic q, input logic f);
    push  = p;
    din   = d;
    pop   = q;
    flush = f;
  endtask

  initial begin
    RST = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    chk("rst_full", DW'(full), DW'(0));
    chk("rst_empty", DW'(empty), DW'(1));
    chk("rst_count", DW'(count), DW'(0));
    chk("rst_head", head, '0);
    tick();
    RST = 1'b0;
    tick();

    // Fill with 1..4
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, DW'(i), 1'b0, 1'b0);
      tick();
      chk($sformatf("fill_count%0d", i), DW'(count), DW'(i));
    end
    chk("fill_full", DW'(full), DW'(1));
    chk("fill_head", head, DW'(1));
    drive(1'b1, DW'(5), 1'b0, 1'b0);
    tick();
    chk("ovf_count", DW'(count), DW'(4));
    // Push at full alongside a pop: pop taken, push dropped
    drive(1'b1, DW'(5), 1'b1, 1'b0);
    tick();
    chk("ovfpop_count", DW'(count), DW'(3));
    chk("ovfpop_full", DW'(full), DW'(0));
    for (int i = 2; i <= 4; i++) begin
      chk($sformatf("drain_head%0d", i), head, DW'(i));
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
    end
    chk("drain_empty", DW'(empty), DW'(1));
    chk("drain_head0", head, '0);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    chk("underflow_count", DW'(count), DW'(0));

    // Concurrent push/pop at count 2
    drive(1'b1, DW'('h11), 1'b0, 1'b0);
    tick();
    drive(1'b1, DW'('h12), 1'b0, 1'b0);
    tick();
    chk("conc_count0", DW'(count), DW'(2));
    chk("conc_head0", head, DW'('h11));
    drive(1'b1, DW'('hA), 1'b1, 1'b0);
    tick();
    chk("conc_count1", DW'(count), DW'(2));
    chk("conc_head1", head, DW'('h12));
    tick();
    chk("conc_count2", DW'(count), DW'(2));
    chk("conc_head2", head, DW'('hA));
    tick();
    chk("conc_count3", DW'(count), DW'(2));
    chk("conc_head3", head, DW'('hA));
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    tick();
    chk("conc_empty", DW'(empty), DW'(1));
    drive(1'b0, '0, 1'b0, 1'b0);

    // Wrap-around with interleaved push/pop
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, DW'(i), 1'b0, 1'b0);
      tick();
      chk($sformatf("wrap_head%0d", i), head, DW'(i));
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
      chk($sformatf("wrap_empty%0d", i), DW'(empty), DW'(1));
    end

    // Flush beats concurrent push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DW'('h21 + i), 1'b0, 1'b0);
      tick();
    end
    chk("fl_count_pre", DW'(count), DW'(3));
    drive(1'b1, DW'('h99), 1'b1, 1'b1);
    tick();
    chk("fl_empty", DW'(empty), DW'(1));
    chk("fl_count", DW'(count), DW'(0));
    chk("fl_head", head, '0);
    drive(1'b1, DW'('h31), 1'b0, 1'b0);
    tick();
    chk("fl_after_head", head, DW'('h31));
    chk("fl_after_count", DW'(count), DW'(1));
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();

    // Asynchronous reset mid-cycle
    drive(1'b1, DW'('h41), 1'b0, 1'b0);
    tick();
    drive(1'b1, DW'('h42), 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("ar_count_pre", DW'(count), DW'(2));
    RST = 1'b1;
    #1;
    chk("ar_count", DW'(count), DW'(0));
    chk("ar_empty", DW'(empty), DW'(1));
    chk("ar_full", DW'(full), DW'(0));
    chk("ar_head", head, '0);
    #1;
    RST = 1'b0;
    drive(1'b1, DW'('h55), 1'b0, 1'b0);
    tick();
    chk("ar_push_head", head, DW'('h55));
    chk("ar_push_empty", DW'(empty), DW'(0));
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("byp_count_pre", DW'(count), DW'(0));

    // Push and pop together on an empty queue
    drive(1'b1, DW'('h77), 1'b1, 1'b0);
    #1;
`ifdef INSTR_FIFO_BYPASS_EN
    chk("byp_head", head, DW'('h77));
    chk("byp_empty", DW'(empty), DW'(0));
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("byp_count_post", DW'(count), DW'(0));
    chk("byp_empty_post", DW'(empty), DW'(1));
`else
    chk("byp_head", head, '0);
    chk("byp_empty", DW'(empty), DW'(1));
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("byp_count_post", DW'(count), DW'(1));
    chk("byp_head_post", head, DW'('h77));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
